// File: rtl/fifo8x9_ctrl.sv
// Valid/ready front-end for the 256x9 FIFO storage block. It drives the FIFO
// write/read/clear strobes and prefetches into a 2-entry output buffer.
module fifo8x9_ctrl #(
  parameter int DW    = 9,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  input  logic          flush,
  output logic [DW-1:0] fifo_din,
  output logic          fifo_wren,
  output logic          fifo_wrinc,
  output logic          fifo_rden,
  output logic          fifo_rdinc,
  output logic          fifo_rdclr,
  output logic          fifo_wrclr,
  input  logic [DW-1:0] fifo_dout,
  output logic [AW:0]   fill_level,
  output logic          full,
  output logic          empty
);

  // state | meaning
  // INIT  | single cycle after reset release; clears both FIFO pointers
  // RUN   | streaming; flush clears pointers and local state
  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam logic [AW:0] FILL_MAX = (AW+1)'(DEPTH);

  state_t        state_q, state_d;
  logic [AW:0]   fill_q, fill_d;
  logic          inflight_q, inflight_d;
  logic [1:0]    buf_cnt_q, buf_cnt_d;
  logic [DW-1:0] buf0_q, buf0_d;
  logic [DW-1:0] buf1_q, buf1_d;

  logic          run;
  logic          flush_run;
  logic          wr_fire;
  logic          rd_fire;
  logic          pop;
  logic [2:0]    occ;
  logic [1:0]    cnt_after_pop;

  always_comb begin
    run        = (state_q == ST_RUN);
    flush_run  = run && flush;

    full       = (fill_q == FILL_MAX);
    empty      = (fill_q == '0) && !inflight_q && (buf_cnt_q == 2'd0);
    fill_level = fill_q;

    in_ready   = run && !full && !flush;
    wr_fire    = in_valid && in_ready;

    out_valid  = run && !flush && (buf_cnt_q != 2'd0);
    out_data   = buf0_q;
    pop        = out_valid && out_ready;

    // Buffer slots already committed once this cycle's pop is accounted for.
    occ        = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    rd_fire    = run && !flush && (fill_q != '0) && (occ < 3'd2);

    fifo_din   = in_data;
    fifo_wren  = wr_fire;
    fifo_wrinc = wr_fire;
    fifo_rden  = rd_fire;
    fifo_rdinc = rd_fire;
    // Gated by rst so the clear strobes stay low while reset is held.
    fifo_rdclr = rst && (!run || flush);
    fifo_wrclr = rst && (!run || flush);
  end

  always_comb begin
    state_d    = ST_RUN;
    inflight_d = rd_fire;

    fill_d = fill_q;
    if (flush_run) begin
      fill_d = '0;
    end else if (wr_fire && !rd_fire) begin
      fill_d = fill_q + 1'b1;
    end else if (rd_fire && !wr_fire) begin
      fill_d = fill_q - 1'b1;
    end

    buf0_d        = buf0_q;
    buf1_d        = buf1_q;
    cnt_after_pop = buf_cnt_q - {1'b0, pop};
    if (pop) begin
      buf0_d = buf1_q;
    end
    if (inflight_q) begin
      if (cnt_after_pop == 2'd0) begin
        buf0_d = fifo_dout;
      end else begin
        buf1_d = fifo_dout;
      end
      buf_cnt_d = cnt_after_pop + 2'd1;
    end else begin
      buf_cnt_d = cnt_after_pop;
    end
    if (flush_run) begin
      buf_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_INIT;
      fill_q     <= '0;
      inflight_q <= 1'b0;
      buf_cnt_q  <= 2'd0;
      buf0_q     <= '0;
      buf1_q     <= '0;
    end else begin
      state_q    <= state_d;
      fill_q     <= fill_d;
      inflight_q <= inflight_d;
      buf_cnt_q  <= buf_cnt_d;
      buf0_q     <= buf0_d;
      buf1_q     <= buf1_d;
    end
  end

endmodule
